// File: rtl/uart_rx_fifo.sv
// UART receiver with 2-flop synchronized RX, runtime parity/stop selection, sticky error flags and FWFT FIFO.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int CLOCKS_PER_BIT  = 434,
  parameter int DATA_BITS       = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int CLOCK_CTR_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        serial_data_in,
  input  logic [1:0]                  parity_type,
  input  logic                        stop_bits,
  input  logic                        rd_en,
  input  logic                        clr_err,
  output logic [DATA_BITS-1:0]        rd_data,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        parity_error,
  output logic                        framing_error,
  output logic                        overrun,
  output logic                        break_detected,
  output logic [1:0]                  parity_leds
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CLOCK_CTR_WIDTH-1:0] CTR_HALF = CLOCK_CTR_WIDTH'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CLOCK_CTR_WIDTH-1:0] CTR_FULL = CLOCK_CTR_WIDTH'(CLOCKS_PER_BIT - 1);
  localparam logic [BW-1:0]              LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [AW:0]                DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
`ifdef UART_RX_BREAK_DETECT_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
  state_t state, state_nxt;

  logic                       rx_meta, rx_sync, rx_prev;
  logic [CLOCK_CTR_WIDTH-1:0] ctr;
  logic [BW-1:0]              bit_idx;
  logic [DATA_BITS-1:0]       shreg;
  logic                       par_en, par_odd, two_stop, par_bad, frm_bad, par_zero, brk_wait;
  logic                       tick, start_edge, frame_end, brk_now, stop_bad;
  logic                       evt_good, evt_par, evt_frm, evt_brk;
  logic [DATA_BITS-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic                       push, pop;

  always_comb begin
    state_nxt  = state;
    frame_end  = 1'b0;
    tick       = (ctr == '0);
    start_edge = rx_prev & ~rx_sync;
    stop_bad   = ~rx_sync | frm_bad;
    // A break is an all-zero frame up to and including the first stop sample
    brk_now    = BRK_EN && (state == STOP1) && tick && !rx_sync && (shreg == '0) && par_zero;
    case (state)
      IDLE:   if (start_edge && !brk_wait) state_nxt = START;
      START:  if (tick) state_nxt = rx_sync ? IDLE : DATA;
      DATA:   if (tick && bit_idx == LAST_BIT) state_nxt = par_en ? PARITY : STOP1;
      PARITY: if (tick) state_nxt = STOP1;
      STOP1:  if (tick) begin
                if (two_stop && !brk_now) begin
                  state_nxt = STOP2;
                end else begin
                  state_nxt = IDLE;
                  frame_end = 1'b1;
                end
              end
      STOP2:  if (tick) begin
                state_nxt = IDLE;
                frame_end = 1'b1;
              end
      default: state_nxt = IDLE;
    endcase
  end

  // Receive control: synchronizer, bit timing, frame status and end-of-frame events
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      state    <= IDLE;
      ctr      <= '0;
      bit_idx  <= '0;
      par_en   <= 1'b0;
      par_odd  <= 1'b0;
      two_stop <= 1'b0;
      par_bad  <= 1'b0;
      frm_bad  <= 1'b0;
      par_zero <= 1'b1;
      brk_wait <= 1'b0;
      evt_good <= 1'b0;
      evt_par  <= 1'b0;
      evt_frm  <= 1'b0;
      evt_brk  <= 1'b0;
    end else begin
      rx_meta  <= serial_data_in;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      state    <= state_nxt;
      evt_good <= 1'b0;
      evt_par  <= 1'b0;
      evt_frm  <= 1'b0;
      evt_brk  <= 1'b0;
      if (state == IDLE) begin
        if (brk_wait) begin
          // after a break the line must stay high for a full bit before a new start
          if (!rx_sync)  ctr <= CTR_FULL;
          else if (tick) brk_wait <= 1'b0;
          else           ctr <= ctr - 1'b1;
        end else if (start_edge) begin
          ctr      <= CTR_HALF;
          bit_idx  <= '0;
          par_en   <= (parity_type == 2'd1) || (parity_type == 2'd2);
          par_odd  <= (parity_type == 2'd1);
          two_stop <= stop_bits;
          par_bad  <= 1'b0;
          frm_bad  <= 1'b0;
          par_zero <= 1'b1;
        end
      end else if (tick) begin
        ctr <= CTR_FULL;
        if (state == DATA) bit_idx <= bit_idx + 1'b1;
        if (state == PARITY) begin
          par_bad  <= ^{shreg, rx_sync} ^ par_odd;
          par_zero <= ~rx_sync;
        end
        if (state == STOP1) frm_bad <= ~rx_sync;
        if (frame_end) begin
          evt_brk  <= brk_now;
          evt_par  <= par_bad & ~brk_now;
          evt_frm  <= stop_bad & ~brk_now;
          evt_good <= ~par_bad & ~stop_bad & ~brk_now;
          brk_wait <= brk_now;
        end
      end else begin
        ctr <= ctr - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == DATA && tick) shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
    if (push) mem[wr_ptr] <= shreg;
  end

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign pop     = rd_en & ~empty;
  assign push    = evt_good & (~full | pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // FIFO bookkeeping, sticky flags and parity LEDs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      parity_error   <= 1'b0;
      framing_error  <= 1'b0;
      overrun        <= 1'b0;
      break_detected <= 1'b0;
      parity_leds    <= 2'b00;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      parity_error   <= evt_par | (parity_error & ~clr_err);
      framing_error  <= evt_frm | (framing_error & ~clr_err);
      overrun        <= (evt_good & full & ~rd_en) | (overrun & ~clr_err);
      break_detected <= evt_brk | (break_detected & ~clr_err);
      if (evt_par)   parity_leds <= 2'b10;
      else if (push) parity_leds <= {1'b0, par_en};
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo: frames are driven bit by bit and checked against a queue-based frame model.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int CPB   = 16;
  localparam int DB    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst, serial_data_in, stop_bits, rd_en, clr_err;
  logic [1:0] parity_type;
  logic [DB-1:0] rd_data;
  logic empty, full, parity_error, framing_error, overrun, break_detected;
  logic [$clog2(DEPTH):0] count;
  logic [1:0] parity_leds;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_fall = 0;
  logic empty_q = 1'b1;

  logic [DB-1:0] m_q[$];
  logic m_perr, m_ferr, m_ovr, m_brk;
  logic [1:0] m_leds;

  uart_rx_fifo #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .CLOCK_CTR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .serial_data_in(serial_data_in), .parity_type(parity_type),
    .stop_bits(stop_bits), .rd_en(rd_en), .clr_err(clr_err), .rd_data(rd_data),
    .empty(empty), .full(full), .count(count), .parity_error(parity_error),
    .framing_error(framing_error), .overrun(overrun), .break_detected(break_detected),
    .parity_leds(parity_leds)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    empty_q <= empty;
    if (empty_q && !empty) last_fall <= cyc;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [DB-1:0] head;
    head = (m_q.size() != 0) ? m_q[0] : '0;
    chk({tag, ".count"}, count, m_q.size());
    chk({tag, ".empty"}, empty, m_q.size() == 0);
    chk({tag, ".full"}, full, m_q.size() == DEPTH);
    chk({tag, ".rd_data"}, rd_data, head);
    chk({tag, ".parity_error"}, parity_error, m_perr);
    chk({tag, ".framing_error"}, framing_error, m_ferr);
    chk({tag, ".overrun"}, overrun, m_ovr);
    chk({tag, ".break"}, break_detected, m_brk);
    chk({tag, ".leds"}, parity_leds, m_leds);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_pop();
    @(negedge clk) rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
    if (m_q.size() != 0) void'(m_q.pop_front());
  endtask

  task automatic clear();
    @(negedge clk) clr_err = 1'b1;
    @(negedge clk) clr_err = 1'b0;
    m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_brk = 1'b0;
  endtask

  // Drives one frame and then applies the frame rules to the model.
  task automatic send_frame(input logic [DB-1:0] d, input logic [1:0] pt, input logic sb,
                            input logic pflip, input logic s1, input logic s2);
    logic bits[$];
    logic par_on;
    par_on = (pt == 2'd1) || (pt == 2'd2);
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(d[i]);
    if (par_on) bits.push_back(((pt == 2'd1) ? ~^d : ^d) ^ pflip);
    bits.push_back(s1);
    if (sb) bits.push_back(s2);
    @(negedge clk);
    parity_type = pt;
    stop_bits   = sb;
    foreach (bits[i]) begin
      serial_data_in = bits[i];
      if (i == 1) begin
        parity_type = 2'($urandom_range(0, 3));
        stop_bits   = 1'($urandom_range(0, 1));
      end
      repeat (CPB) @(negedge clk);
    end
    serial_data_in = 1'b1;
    if (par_on && pflip) begin
      m_perr = 1'b1;
      m_leds = 2'b10;
    end
    if (!s1 || (sb && !s2)) m_ferr = 1'b1;
    if (!(par_on && pflip) && s1 && (!sb || s2)) begin
      if (m_q.size() == DEPTH) m_ovr = 1'b1;
      else begin
        m_q.push_back(d);
        m_leds = par_on ? 2'b01 : 2'b00;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [DB-1:0] d;
    logic [1:0] pt;
    logic sb, pflip, s1, s2;
    rst = 1'b0; serial_data_in = 1'b1; parity_type = 2'd0; stop_bits = 1'b0;
    rd_en = 1'b0; clr_err = 1'b0;
    m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_brk = 1'b0; m_leds = 2'b00;
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b1;
    idle(2 * CPB);

    t0 = cyc + 1;
    send_frame(8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(CPB);
    chk("a5.latency_in_window", (last_fall - t0 >= 9 * CPB) && (last_fall - t0 <= 11 * CPB), 1'b1);
    check_all("a5");

    send_frame(8'h03, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1); idle(CPB); check_all("even_ok");
    send_frame(8'h03, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1); idle(CPB); check_all("even_bad");
    clear(); check_all("even_clr");

    send_frame(8'h5A, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0); idle(CPB); check_all("stop2_bad");
    clear();
    while (m_q.size() != 0) begin check_all("drain1"); do_pop(); end
    check_all("drained1");

    for (int v = 1; v <= 5; v++) begin
      send_frame(DB'(v), 2'd0, 1'b0, 1'b0, 1'b1, 1'b1); idle(CPB); check_all("fill");
    end
    while (m_q.size() != 0) begin check_all("pop_order"); do_pop(); end
    check_all("pop_empty");
    do_pop(); check_all("pop_when_empty");
    clear();

    for (int v = 'h11; v <= 'h14; v++) begin
      send_frame(DB'(v), 2'd0, 1'b0, 1'b0, 1'b1, 1'b1); idle(CPB);
    end
    check_all("refill");
    fork
      send_frame(8'h15, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        @(negedge clk);
        repeat (155) @(negedge clk);
        rd_en = 1'b1;
        void'(m_q.pop_front());
        @(negedge clk) rd_en = 1'b0;
      end
    join
    idle(CPB);
    check_all("coincident");
    while (m_q.size() != 0) do_pop();
    check_all("drained2");

    @(negedge clk) serial_data_in = 1'b0;
    repeat (4) @(negedge clk);
    serial_data_in = 1'b1;
    idle(3 * CPB);
    check_all("glitch");

    for (int n = 0; n < 24; n++) begin
      d     = DB'($urandom);
      pt    = 2'($urandom_range(0, 3));
      sb    = 1'($urandom_range(0, 1));
      pflip = ($urandom_range(0, 5) == 0);
      s1    = !((d != '0) && ($urandom_range(0, 7) == 0));
      s2    = !($urandom_range(0, 5) == 0);
      send_frame(d, pt, sb, pflip, s1, s2);
      idle(CPB);
      check_all("rand");
      if ($urandom_range(0, 2) == 0) begin do_pop(); check_all("rand_pop"); end
      if ($urandom_range(0, 3) == 0) clear();
    end
    clear();
    while (m_q.size() != 0) do_pop();

    @(negedge clk) begin parity_type = 2'd0; stop_bits = 1'b0; serial_data_in = 1'b0; end
    repeat (12 * CPB) @(negedge clk);
    serial_data_in = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
    m_brk = 1'b1;
`else
    m_ferr = 1'b1;
`endif
    idle(2 * CPB);
    check_all("break");
    send_frame(8'hC3, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1); idle(CPB); check_all("after_break");
    clear();

    send_frame(8'h3C, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1); idle(CPB); check_all("pre_rst");
    @(negedge clk) serial_data_in = 1'b0;
    repeat (5 * CPB) @(negedge clk);
    rst = 1'b0;
    #1;
    m_q.delete();
    m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_brk = 1'b0; m_leds = 2'b00;
    check_all("rst_mid");
    serial_data_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(12 * CPB);
    check_all("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver for the board-level UART designs. Compared with the previous receiver it adds:
- runtime-selectable parity and stop-bit count
- framing-error and overrun detection with sticky flags
- a first-word-fall-through receive FIFO, so bytes survive until the consumer (display/LED logic, future command parser) reads them

It drives the 2-bit parity status LEDs directly.

Parameters:
CLOCKS_PER_BIT, 434, clk cycles per bit (BASE_CLK/BAUDRATE); must be >= 4
DATA_BITS, 8, data bits per frame, 5..9, sent LSB first
FIFO_DEPTH, 4, FIFO entries; power of two, >= 2
CLOCK_CTR_WIDTH, 32, width of the bit-timing counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (0 = reset)
serial_data_in  in  1  RX line from GPIO, idle high, asynchronous
parity_type  in  2  0 none, 1 odd, 2 even, 3 treated as none
stop_bits  in  1  0 = one stop bit, 1 = two stop bits
rd_en  in  1  pop head entry
clr_err  in  1  single-cycle pulse; clears sticky error flags
rd_data  out  DATA_BITS  FIFO head (valid when empty=0)
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  $clog2(FIFO_DEPTH)+1  entries held
parity_error  out  1  sticky parity-error flag
framing_error  out  1  sticky framing-error flag
overrun  out  1  sticky overrun flag
break_detected  out  1  sticky break flag (see Optional Feature)
parity_leds  out  2  00 parity off, 01 last frame OK, 10 last frame parity bad

Behaviour:
- Reset (rst=0, async):
  - FSM=IDLE; synchronizer flops=1
  - FIFO empty: empty=1, full=0, count=0, rd_data=0
  - all sticky flags=0; parity_leds=00
- A reset mid-frame aborts the frame; nothing is pushed.
- Input: 2-flop synchronizer. Start is detected on a synchronized 1->0 transition in IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE->START: on a falling edge. Latch parity_type and stop_bits; changes to them mid-frame are ignored. Load the counter to sample at CLOCKS_PER_BIT/2-1.
  - START: sample at mid-bit. If the line is 1, it is a glitch -> IDLE with no flags. Otherwise -> DATA.
  - DATA: DATA_BITS samples, one every CLOCKS_PER_BIT, shifted in LSB first. Then -> PARITY if parity is enabled, else -> STOP1.
  - PARITY: compare the sample against the computed bit. Odd: XOR(data, p) must be 1. Even: XOR(data, p) must be 0.
  - STOP1: sample must be 1, else framing error. -> STOP2 if two stop bits are selected, else frame end.
  - STOP2: same check as STOP1, then frame end.
  - Frame end: at the final mid-stop sample -> IDLE directly, so a back-to-back start is caught.
- Frame end actions, registered one cycle after the final stop sample:
  - Parity mismatch: parity_error<=1, parity_leds<=10, no push.
  - Stop sampled 0: framing_error<=1, no push.
  - Good frame while full and no rd_en in the same cycle: overrun<=1, frame dropped; FIFO contents unchanged.
  - Good frame otherwise: push. parity_leds<=01 if parity is on, 00 if off.
  - empty falls on the cycle after the push.
- FIFO:
  - rd_data is the head register (FWFT).
  - rd_en while empty is ignored.
  - Push and pop in the same cycle: count unchanged. This is legal even when full.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Sticky flags clear on clr_err=1. If a set event and clr_err occur in the same cycle, set wins.

Optional Feature:
Macro UART_RX_BREAK_DETECT_EN.
- Defined: a frame whose start, all data bits, the parity bit (if enabled) and the first stop sample are all 0 sets break_detected. It is not flagged as a framing error and nothing is pushed. The FSM then waits in IDLE until the line has returned high for one full bit time before accepting a new start.
- Undefined: break_detected is tied to 0, and a break is handled as an ordinary framing error.

Test Plan:
- CLOCKS_PER_BIT=16, no parity, 1 stop, send 0xA5 -> empty falls ~10 bit times after start, rd_data=0xA5, count=1, all flags 0, parity_leds=00.
- Even parity, send 0x03 with parity bit 0 -> pushed, parity_leds=01. Then send 0x03 with parity bit 1 -> not pushed, parity_error=1, parity_leds=10. Then clr_err -> parity_error=0.
- Two stop bits, send 0x5A with the second stop bit driven 0 -> framing_error=1, count unchanged.
- FIFO_DEPTH=4: send 0x01..0x05 without reading -> full=1, count=4, overrun=1. Pops return 0x01, 0x02, 0x03, 0x04, then empty=1. A pop coincident with a fifth arrival -> no overrun.
- 0-pulse of 4 clocks on the line -> false start, no push, no flags. Assert rst=0 mid-frame -> all outputs return to reset values immediately.
- With UART_RX_BREAK_DETECT_EN: hold the line low for 12 bit times -> break_detected=1, framing_error=0, count=0. Without the macro: framing_error=1.
